// File: rtl/vedic_pkg.sv
// ---------------------------------------------------------------------------
// vedic_pkg
// Shared definitions for the pipelined Vedic multiplier:
//   VM_LATENCY  - cycles from input transfer to out_valid with no stall
//   VM_ABS_MAX  - widest operand the magnitude helper handles
//   vm_stage_t  - per-stage control record (valid bit and result sign)
//   vedic_abs() - WIDTH-bit magnitude of an operand, optionally signed
// No ports; imported by the multiplier files.
// ---------------------------------------------------------------------------
package vedic_pkg;

    localparam int VM_LATENCY = 4;
    localparam int VM_ABS_MAX = 64;

    // Control travelling down the pipe with each operand pair. Tag and data
    // widths differ per stage, so those sit in separate registers beside it.
    typedef struct packed {
        logic valid;
        logic neg;
    } vm_stage_t;

    // Magnitude of the low 'width' bits of 'value'. In signed mode the most
    // negative value maps to 2^(width-1), which still fits in width bits.
    function automatic logic [VM_ABS_MAX-1:0] vedic_abs(
        input int                    width,
        input logic [VM_ABS_MAX-1:0] value,
        input logic                  signed_en
    );
        logic [VM_ABS_MAX-1:0] mask;
        logic [VM_ABS_MAX-1:0] v;
        logic [VM_ABS_MAX-1:0] result;
        mask   = (VM_ABS_MAX'(1) << width) - VM_ABS_MAX'(1);
        v      = value & mask;
        result = v;
        if (signed_en && (((v >> (width - 1)) & VM_ABS_MAX'(1)) != '0)) begin
            result = (~v + VM_ABS_MAX'(1)) & mask;
        end
        return result;
    endfunction

endpackage

// File: rtl/vedic_nxn_comb.sv
// ---------------------------------------------------------------------------
// vedic_nxn_comb
// Combinational unsigned N x N Urdhva-Tiryagbhyam multiplier. N must be a
// power of two. Each level splits the operands into halves, forms the four
// cross products with recursive instances, and combines them vertically and
// crosswise; recursion bottoms out in a 2x2 gate-level cell.
// Ports:
//   a  in   N     multiplicand (unsigned)
//   b  in   N     multiplier   (unsigned)
//   p  out  2*N   product
// ---------------------------------------------------------------------------
module vedic_nxn_comb #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    generate
        if (N == 1) begin : g_bit
            assign p = {1'b0, a & b};
        end else if (N == 2) begin : g_cell
            // 2x2 cell: the two crosswise bit products meet in a half adder,
            // whose carry then meets the vertical high-bit product.
            logic cross_c;
            assign cross_c = (a[1] & b[0]) & (a[0] & b[1]);
            assign p[0]    = a[0] & b[0];
            assign p[1]    = (a[1] & b[0]) ^ (a[0] & b[1]);
            assign p[2]    = (a[1] & b[1]) ^ cross_c;
            assign p[3]    = (a[1] & b[1]) & cross_c;
        end else begin : g_split
            localparam int M = N / 2;
            logic [N-1:0] ll;
            logic [N-1:0] hl;
            logic [N-1:0] lh;
            logic [N-1:0] hh;
            logic [N:0]   mid;

            vedic_nxn_comb #(.N(M)) u_ll (.a(a[M-1:0]), .b(b[M-1:0]), .p(ll));
            vedic_nxn_comb #(.N(M)) u_hl (.a(a[N-1:M]), .b(b[M-1:0]), .p(hl));
            vedic_nxn_comb #(.N(M)) u_lh (.a(a[M-1:0]), .b(b[N-1:M]), .p(lh));
            vedic_nxn_comb #(.N(M)) u_hh (.a(a[N-1:M]), .b(b[N-1:M]), .p(hh));

            // The two crosswise products share weight 2^M; their carry-out
            // is kept so the final addition never loses a bit.
            assign mid = {1'b0, hl} + {1'b0, lh};
            assign p   = {hh, ll} + ({{(N-1){1'b0}}, mid} << M);
        end
    endgenerate

endmodule

// File: rtl/vedic_mult_pipe.sv
// ---------------------------------------------------------------------------
// vedic_mult_pipe
// Four-stage pipelined WIDTH x WIDTH Vedic multiplier with valid/ready on
// both sides. Each transaction selects unsigned or two's-complement operands
// and carries an opaque tag that comes back with its product.
//   S1: operand magnitudes, result sign, tag
//   S2: four half-width quadrant products (LL, HL, LH, HH)
//   S3: crosswise sum HL+LH with carry, plus LL and HH passed along
//   S4: full product assembled and negated when the sign says so
// The whole pipe advances together; it stalls only when a finished result is
// waiting and the consumer is not taking it.
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        pipe can accept this cycle
//   in_a       in   WIDTH    multiplicand
//   in_b       in   WIDTH    multiplier
//   in_signed  in   1        1 = two's-complement operands, 0 = unsigned
//   in_tag     in   TAG_W    returned unchanged with the product
//   out_valid  out  1        product valid
//   out_ready  in   1        consumer accepts the product
//   out_prod   out  2*WIDTH  product
//   out_tag    out  TAG_W    tag of this product
// ---------------------------------------------------------------------------
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int H = WIDTH / 2;

    logic adv;

    vm_stage_t        s1_ctrl_q, s1_ctrl_d;
    logic [TAG_W-1:0] s1_tag_q,  s1_tag_d;
    logic [WIDTH-1:0] s1_a_q,    s1_a_d;
    logic [WIDTH-1:0] s1_b_q,    s1_b_d;

    vm_stage_t        s2_ctrl_q, s2_ctrl_d;
    logic [TAG_W-1:0] s2_tag_q,  s2_tag_d;
    logic [WIDTH-1:0] s2_ll_q,   s2_ll_d;
    logic [WIDTH-1:0] s2_hl_q,   s2_hl_d;
    logic [WIDTH-1:0] s2_lh_q,   s2_lh_d;
    logic [WIDTH-1:0] s2_hh_q,   s2_hh_d;

    vm_stage_t        s3_ctrl_q, s3_ctrl_d;
    logic [TAG_W-1:0] s3_tag_q,  s3_tag_d;
    logic [WIDTH-1:0] s3_ll_q,   s3_ll_d;
    logic [WIDTH:0]   s3_mid_q,  s3_mid_d;
    logic [WIDTH-1:0] s3_hh_q,   s3_hh_d;

    vm_stage_t          s4_ctrl_q, s4_ctrl_d;
    logic [TAG_W-1:0]   s4_tag_q,  s4_tag_d;
    logic [2*WIDTH-1:0] s4_prod_q, s4_prod_d;

    logic [WIDTH-1:0]   quad_ll;
    logic [WIDTH-1:0]   quad_hl;
    logic [WIDTH-1:0]   quad_lh;
    logic [WIDTH-1:0]   quad_hh;
    logic [2*WIDTH-1:0] mag_sum;

    // Quadrant products of the S1 magnitudes feed the S2 registers.
    vedic_nxn_comb #(.N(H)) u_quad_ll (.a(s1_a_q[H-1:0]),     .b(s1_b_q[H-1:0]),     .p(quad_ll));
    vedic_nxn_comb #(.N(H)) u_quad_hl (.a(s1_a_q[WIDTH-1:H]), .b(s1_b_q[H-1:0]),     .p(quad_hl));
    vedic_nxn_comb #(.N(H)) u_quad_lh (.a(s1_a_q[H-1:0]),     .b(s1_b_q[WIDTH-1:H]), .p(quad_lh));
    vedic_nxn_comb #(.N(H)) u_quad_hh (.a(s1_a_q[WIDTH-1:H]), .b(s1_b_q[WIDTH-1:H]), .p(quad_hh));

    // A single advance enable drives every stage, so bubbles hold in place
    // during a stall. in_ready depends only on state and out_ready.
    always_comb begin
        adv       = ~s4_ctrl_q.valid | out_ready;
        in_ready  = adv;
        out_valid = s4_ctrl_q.valid;
        out_prod  = s4_prod_q;
        out_tag   = s4_tag_q;
    end

    // Stage data loads only when the stage above it holds a real
    // transaction, so idle inputs (possibly X) never enter the datapath.
    always_comb begin
        s1_ctrl_d = s1_ctrl_q;
        s1_tag_d  = s1_tag_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s2_ctrl_d = s2_ctrl_q;
        s2_tag_d  = s2_tag_q;
        s2_ll_d   = s2_ll_q;
        s2_hl_d   = s2_hl_q;
        s2_lh_d   = s2_lh_q;
        s2_hh_d   = s2_hh_q;
        s3_ctrl_d = s3_ctrl_q;
        s3_tag_d  = s3_tag_q;
        s3_ll_d   = s3_ll_q;
        s3_mid_d  = s3_mid_q;
        s3_hh_d   = s3_hh_q;
        s4_ctrl_d = s4_ctrl_q;
        s4_tag_d  = s4_tag_q;
        s4_prod_d = s4_prod_q;
        mag_sum   = {s3_hh_q, s3_ll_q} + ({{(WIDTH-1){1'b0}}, s3_mid_q} << H);

        if (adv) begin
            s1_ctrl_d.valid = in_valid;
            if (in_valid) begin
                s1_ctrl_d.neg = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                s1_tag_d      = in_tag;
                s1_a_d        = WIDTH'(vedic_abs(WIDTH, VM_ABS_MAX'(in_a), in_signed));
                s1_b_d        = WIDTH'(vedic_abs(WIDTH, VM_ABS_MAX'(in_b), in_signed));
            end

            s2_ctrl_d.valid = s1_ctrl_q.valid;
            if (s1_ctrl_q.valid) begin
                s2_ctrl_d.neg = s1_ctrl_q.neg;
                s2_tag_d      = s1_tag_q;
                s2_ll_d       = quad_ll;
                s2_hl_d       = quad_hl;
                s2_lh_d       = quad_lh;
                s2_hh_d       = quad_hh;
            end

            s3_ctrl_d.valid = s2_ctrl_q.valid;
            if (s2_ctrl_q.valid) begin
                s3_ctrl_d.neg = s2_ctrl_q.neg;
                s3_tag_d      = s2_tag_q;
                s3_ll_d       = s2_ll_q;
                s3_mid_d      = {1'b0, s2_hl_q} + {1'b0, s2_lh_q};
                s3_hh_d       = s2_hh_q;
            end

            s4_ctrl_d.valid = s3_ctrl_q.valid;
            if (s3_ctrl_q.valid) begin
                s4_ctrl_d.neg = s3_ctrl_q.neg;
                s4_tag_d      = s3_tag_q;
                s4_prod_d     = s3_ctrl_q.neg ? ('0 - mag_sum) : mag_sum;
            end
        end
    end

    // Reset clears data as well as valids so the outputs read zero and any
    // in-flight transactions are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ctrl_q <= '0;
            s1_tag_q  <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s2_ctrl_q <= '0;
            s2_tag_q  <= '0;
            s2_ll_q   <= '0;
            s2_hl_q   <= '0;
            s2_lh_q   <= '0;
            s2_hh_q   <= '0;
            s3_ctrl_q <= '0;
            s3_tag_q  <= '0;
            s3_ll_q   <= '0;
            s3_mid_q  <= '0;
            s3_hh_q   <= '0;
            s4_ctrl_q <= '0;
            s4_tag_q  <= '0;
            s4_prod_q <= '0;
        end else begin
            s1_ctrl_q <= s1_ctrl_d;
            s1_tag_q  <= s1_tag_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s2_ctrl_q <= s2_ctrl_d;
            s2_tag_q  <= s2_tag_d;
            s2_ll_q   <= s2_ll_d;
            s2_hl_q   <= s2_hl_d;
            s2_lh_q   <= s2_lh_d;
            s2_hh_q   <= s2_hh_d;
            s3_ctrl_q <= s3_ctrl_d;
            s3_tag_q  <= s3_tag_d;
            s3_ll_q   <= s3_ll_d;
            s3_mid_q  <= s3_mid_d;
            s3_hh_q   <= s3_hh_d;
            s4_ctrl_q <= s4_ctrl_d;
            s4_tag_q  <= s4_tag_d;
            s4_prod_q <= s4_prod_d;
        end
    end

endmodule
